// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR constants, next-state function and checker state encoding
package lfsr_pkg;

    localparam int LFSR_WIDTH = 3;
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 3'b110;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] s);
        return {s[LFSR_WIDTH-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr_seq_checker_if.sv
// rtl/lfsr_seq_checker_if.sv - sample stream and status bundle of the LFSR sequence checker
interface lfsr_seq_checker_if
    import lfsr_pkg::*;
#(
    parameter int WIDTH = LFSR_WIDTH,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_state;
    logic             clr_cnt;
    logic             locked;
    logic             err_pulse;
    logic             zero_err;
    logic [CNT_W-1:0] err_count;

    modport master (
        output in_valid, in_state, clr_cnt,
        input  locked, err_pulse, zero_err, err_count
    );

    modport slave (
        input  in_valid, in_state, clr_cnt,
        output locked, err_pulse, zero_err, err_count
    );
endinterface

// File: rtl/lfsr_predict.sv
// rtl/lfsr_predict.sv - combinational Fibonacci LFSR next-state, shared with the generator
module lfsr_predict
    import lfsr_pkg::*;
#(
    parameter int                WIDTH = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS
) (
    input  logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next
);
    assign next = {state[WIDTH-2:0], ^(state & TAPS)};
endmodule

// File: rtl/lfsr_seq_checker.sv
// rtl/lfsr_seq_checker.sv - predicts each LFSR word from the previous one, tracks lock and counts errors
module lfsr_seq_checker
    import lfsr_pkg::*;
#(
    parameter int                WIDTH    = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] TAPS     = LFSR_TAPS,
    parameter int                LOCK_CNT = 4,
    parameter int                LOSS_CNT = 3,
    parameter int                CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    lfsr_seq_checker_if.slave  bus
);
    localparam logic [3:0]       LOCK_C  = 4'(LOCK_CNT);
    localparam logic [3:0]       LOSS_C  = 4'(LOSS_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    chk_state_t       state, state_n;
    logic             have_prev, have_prev_n;
    logic [WIDTH-1:0] pred, pred_n, pred_next;
    logic [3:0]       run_cnt, run_n;
    logic [3:0]       bad_cnt, bad_n;
    logic [CNT_W-1:0] err_count, cnt_n;
    logic             err_pulse, err_n;
    logic             zero_err, zero_n;
    logic             is_zero, match;

    lfsr_predict #(.WIDTH(WIDTH), .TAPS(TAPS)) u_predict (
        .state (bus.in_state),
        .next  (pred_next)
    );

    assign is_zero = (bus.in_state == '0);
    assign match   = (bus.in_state == pred) && !is_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SEARCH;
            have_prev <= 1'b0;
            pred      <= '0;
            run_cnt   <= '0;
            bad_cnt   <= '0;
            err_count <= '0;
            err_pulse <= 1'b0;
            zero_err  <= 1'b0;
        end else begin
            state     <= state_n;
            have_prev <= have_prev_n;
            pred      <= pred_n;
            run_cnt   <= run_n;
            bad_cnt   <= bad_n;
            err_count <= cnt_n;
            err_pulse <= err_n;
            zero_err  <= zero_n;
        end
    end

    always_comb begin
        state_n     = state;
        have_prev_n = have_prev;
        pred_n      = pred;
        run_n       = run_cnt;
        bad_n       = bad_cnt;
        cnt_n       = err_count;
        err_n       = 1'b0;
        zero_n      = 1'b0;
        if (bus.in_valid) begin
            // Always re-seed from the observed word so one bad word costs at most two errors
            pred_n = pred_next;
            zero_n = is_zero;
            if (!have_prev) begin
                have_prev_n = 1'b1;
            end else begin
                case (state)
                    SEARCH: begin
                        if (match) begin
                            if (run_cnt + 4'd1 == LOCK_C) begin
                                state_n = LOCKED;
                                run_n   = '0;
                                bad_n   = '0;
                            end else begin
                                run_n = run_cnt + 4'd1;
                            end
                        end else begin
                            run_n = '0;
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            bad_n = '0;
                        end else begin
                            err_n = 1'b1;
                            if (err_count != CNT_MAX) cnt_n = err_count + 1'b1;
                            if (bad_cnt + 4'd1 == LOSS_C) begin
                                state_n     = SEARCH;
                                bad_n       = '0;
                                have_prev_n = 1'b0;
                            end else begin
                                bad_n = bad_cnt + 4'd1;
                            end
                        end
                    end
                    default: state_n = SEARCH;
                endcase
            end
        end
        if (bus.clr_cnt) cnt_n = '0;
    end

    assign bus.locked    = (state == LOCKED);
    assign bus.err_pulse = err_pulse;
    assign bus.zero_err  = zero_err;
    assign bus.err_count = err_count;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// tb/tb_lfsr_seq_checker.sv - directed self-checking bench for lfsr_seq_checker
module tb_lfsr_seq_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   idx   = 0;

    // Reference sequence from 001 for taps 110
    logic [2:0] seq [7] = '{3'd1, 3'd2, 3'd5, 3'd3, 3'd7, 3'd6, 3'd4};

    lfsr_seq_checker_if #(.WIDTH(3), .CNT_W(8)) bus ();

    lfsr_seq_checker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic word(input logic v, input logic [2:0] s, input logic clr);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_state = s;
        bus.clr_cnt  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic next_word();
        word(1'b1, seq[idx], 1'b0);
        idx = (idx + 1) % 7;
    endtask

    // Wrong (nonzero) word followed by its own successor: exactly one LOCKED error
    task automatic err_pair();
        idx = (idx + 2) % 7;
        word(1'b1, seq[idx], 1'b0);
        idx = (idx + 1) % 7;
        next_word();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_state = 3'd0;
        bus.clr_cnt  = 1'b0;

        #12;
        chk("rst_locked", 32'(bus.locked), 32'd0);
        chk("rst_err_count", 32'(bus.err_count), 32'd0);
        chk("rst_pulses", 32'({bus.err_pulse, bus.zero_err}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: seed + 4 matches locks
        idx = 0;
        for (int i = 0; i < 5; i++) begin
            next_word();
            chk("t1_locked", 32'(bus.locked), (i == 4) ? 32'd1 : 32'd0);
            chk("t1_err_pulse", 32'(bus.err_pulse), 32'd0);
        end

        // 2: one 111 replaced by 000
        while (idx != 4) next_word();
        word(1'b1, 3'd0, 1'b0);
        idx = 5;
        chk("t2_zero_err", 32'(bus.zero_err), 32'd1);
        chk("t2_err_pulse", 32'(bus.err_pulse), 32'd1);
        chk("t2_count1", 32'(bus.err_count), 32'd1);
        next_word();
        chk("t2_err_after", 32'(bus.err_pulse), 32'd1);
        chk("t2_zero_after", 32'(bus.zero_err), 32'd0);
        chk("t2_count2", 32'(bus.err_count), 32'd2);
        next_word();
        chk("t2_recover", 32'(bus.err_pulse), 32'd0);
        chk("t2_locked", 32'(bus.locked), 32'd1);
        chk("t2_count_hold", 32'(bus.err_count), 32'd2);

        // 3: three consecutive wrong words drop lock, then re-lock
        for (int i = 0; i < 3; i++) begin
            word(1'b1, 3'd2, 1'b0);
            chk("t3_err_pulse", 32'(bus.err_pulse), 32'd1);
            chk("t3_count", 32'(bus.err_count), 32'(3 + i));
            chk("t3_locked", 32'(bus.locked), (i == 2) ? 32'd0 : 32'd1);
        end
        idx = 0;
        for (int i = 0; i < 5; i++) begin
            next_word();
            chk("t3_relock", 32'(bus.locked), (i == 4) ? 32'd1 : 32'd0);
        end
        chk("t3_count_hold", 32'(bus.err_count), 32'd5);

        // 4: in_valid toggled with idle gaps
        do_reset();
        chk("t4_reset_count", 32'(bus.err_count), 32'd0);
        idx = 3;
        for (int i = 0; i < 5; i++) begin
            next_word();
            chk("t4_locked", 32'(bus.locked), (i == 4) ? 32'd1 : 32'd0);
            word(1'b0, 3'd0, 1'b0);
            chk("t4_idle_pulses", 32'({bus.err_pulse, bus.zero_err}), 32'd0);
            chk("t4_idle_locked", 32'(bus.locked), (i == 4) ? 32'd1 : 32'd0);
        end

        // 5: saturation and clear-wins
        for (int i = 0; i < 254; i++) err_pair();
        chk("t5_count_fe", 32'(bus.err_count), 32'hFE);
        chk("t5_locked", 32'(bus.locked), 32'd1);
        err_pair();
        chk("t5_count_ff", 32'(bus.err_count), 32'hFF);
        err_pair();
        chk("t5_count_sat", 32'(bus.err_count), 32'hFF);
        idx = (idx + 2) % 7;
        word(1'b1, seq[idx], 1'b1);
        idx = (idx + 1) % 7;
        chk("t5_clr_err_pulse", 32'(bus.err_pulse), 32'd1);
        chk("t5_clr_wins", 32'(bus.err_count), 32'd0);
        next_word();
        chk("t5_after_clr", 32'(bus.err_count), 32'd0);

        // 6: asynchronous reset between edges while LOCKED
        idx = (idx + 2) % 7;
        word(1'b1, seq[idx], 1'b0);
        idx = (idx + 1) % 7;
        chk("t6_pre_count", 32'(bus.err_count), 32'd1);
        chk("t6_pre_pulse", 32'(bus.err_pulse), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_locked", 32'(bus.locked), 32'd0);
        chk("t6_async_count", 32'(bus.err_count), 32'd0);
        chk("t6_async_pulse", 32'(bus.err_pulse), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idx = 2;
        for (int i = 0; i < 5; i++) begin
            next_word();
            chk("t6_relock", 32'(bus.locked), (i == 4) ? 32'd1 : 32'd0);
            chk("t6_no_err", 32'(bus.err_pulse), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
